// File: rtl/regfile_pkg.sv
// Shared register-file types, constants and address helpers.
package regfile_pkg;

  localparam int unsigned REG_ADDR_W = 4;
  localparam int unsigned REG_WORD_W = 32;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [REG_WORD_W-1:0] reg_word_t;

  localparam int unsigned REG_ZERO = 0;

  // An address names real storage when it is non-zero and below num_regs.
  function automatic logic is_valid_reg(input logic [31:0] addr,
                                        input int unsigned num_regs);
    return (addr != 32'(REG_ZERO)) && (addr < num_regs);
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-bit scoreboard: reservation on issue, release on write-back,
// per-read-port hazard flags and a registered pending count.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int unsigned ADDRESS_SIZE = 4,
  parameter int unsigned NUM_REGS     = 15,
  parameter int unsigned NUM_READ     = 3
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_READ*ADDRESS_SIZE-1:0] src_addr,
  input  logic                           wb0_en,
  input  logic [ADDRESS_SIZE-1:0]        wb0_dest,
  input  logic                           wb1_en,
  input  logic [ADDRESS_SIZE-1:0]        wb1_dest,
  input  logic                           issue_en,
  input  logic [ADDRESS_SIZE-1:0]        issue_dest,
  output logic [NUM_READ-1:0]            hazard,
  output logic [ADDRESS_SIZE:0]          pending_cnt
);

  localparam int unsigned DEPTH = 1 << ADDRESS_SIZE;
  localparam int unsigned CNT_W = ADDRESS_SIZE + 1;

  logic [NUM_REGS-1:0] pending;
  logic [NUM_REGS-1:0] pending_nxt;
  logic [CNT_W-1:0]    cnt_nxt;
  logic [DEPTH-1:0]    pending_full;

  // Next pending vector (set beats clear) and its population count.
  always_comb begin
    pending_nxt = '0;
    cnt_nxt     = '0;
    for (int unsigned r = 1; r < NUM_REGS; r++) begin
      logic set_r;
      logic clr_r;
      set_r = issue_en && (issue_dest == ADDRESS_SIZE'(r));
      clr_r = (wb0_en && (wb0_dest == ADDRESS_SIZE'(r))) ||
              (wb1_en && (wb1_dest == ADDRESS_SIZE'(r)));
      pending_nxt[r] = (pending[r] && !clr_r) || set_r;
      cnt_nxt        = cnt_nxt + CNT_W'(pending_nxt[r]);
    end
  end

  // Pending bits and count; reset drops every reservation.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending     <= '0;
      pending_cnt <= '0;
    end else begin
      pending     <= pending_nxt;
      pending_cnt <= cnt_nxt;
    end
  end

  // Zero-extend so every encodable address indexes a defined bit.
  assign pending_full = DEPTH'(pending);

  // Hazard per port: source reserved and not being completed this cycle.
  always_comb begin
    hazard = '0;
    for (int unsigned k = 0; k < NUM_READ; k++) begin
      logic [ADDRESS_SIZE-1:0] src;
      logic                    wr_hit;
      src    = src_addr[k*ADDRESS_SIZE +: ADDRESS_SIZE];
      wr_hit = (wb0_en && (wb0_dest == src)) || (wb1_en && (wb1_dest == src));
      hazard[k] = is_valid_reg(32'(src), NUM_REGS) && pending_full[src] && !wr_hit;
    end
  end

endmodule

// File: rtl/regfile_mp_sb.sv
// Multi-port register file with two prioritised write-back ports,
// same-cycle read bypass and an attached issue scoreboard.
module regfile_mp_sb
  import regfile_pkg::*;
#(
  parameter int unsigned WORD_SIZE    = 32,
  parameter int unsigned ADDRESS_SIZE = 4,
  parameter int unsigned NUM_REGS     = 15,
  parameter int unsigned NUM_READ     = 3
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_READ*ADDRESS_SIZE-1:0] src_addr,
  output logic [NUM_READ*WORD_SIZE-1:0]    rd_data,
  output logic [NUM_READ-1:0]              hazard,
  input  logic                             wb0_en,
  input  logic                             wb1_en,
  input  logic [ADDRESS_SIZE-1:0]          wb0_dest,
  input  logic [ADDRESS_SIZE-1:0]          wb1_dest,
  input  logic [WORD_SIZE-1:0]             wb0_data,
  input  logic [WORD_SIZE-1:0]             wb1_data,
  input  logic                             issue_en,
  input  logic [ADDRESS_SIZE-1:0]          issue_dest,
  output logic [ADDRESS_SIZE:0]            pending_cnt
);

  logic [WORD_SIZE-1:0] regs [NUM_REGS];

  // Storage update: reset loads each register with its own index,
  // write port 1 wins when both ports target the same register.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        regs[i] <= WORD_SIZE'(i);
      end
    end else begin
      regs[0] <= '0;
      for (int unsigned i = 1; i < NUM_REGS; i++) begin
        if (wb1_en && (wb1_dest == ADDRESS_SIZE'(i))) begin
          regs[i] <= wb1_data;
        end else if (wb0_en && (wb0_dest == ADDRESS_SIZE'(i))) begin
          regs[i] <= wb0_data;
        end
      end
    end
  end

  // Read ports: zero for r0/unimplemented, then wb1, wb0, stored value.
  always_comb begin
    rd_data = '0;
    for (int unsigned k = 0; k < NUM_READ; k++) begin
      logic [ADDRESS_SIZE-1:0] src;
      src = src_addr[k*ADDRESS_SIZE +: ADDRESS_SIZE];
      if (!is_valid_reg(32'(src), NUM_REGS)) begin
        rd_data[k*WORD_SIZE +: WORD_SIZE] = '0;
      end else if (wb1_en && (wb1_dest == src)) begin
        rd_data[k*WORD_SIZE +: WORD_SIZE] = wb1_data;
      end else if (wb0_en && (wb0_dest == src)) begin
        rd_data[k*WORD_SIZE +: WORD_SIZE] = wb0_data;
      end else begin
        rd_data[k*WORD_SIZE +: WORD_SIZE] = regs[src];
      end
    end
  end

  regfile_scoreboard #(
    .ADDRESS_SIZE (ADDRESS_SIZE),
    .NUM_REGS     (NUM_REGS),
    .NUM_READ     (NUM_READ)
  ) u_scoreboard (
    .clk         (clk),
    .rst         (rst),
    .src_addr    (src_addr),
    .wb0_en      (wb0_en),
    .wb0_dest    (wb0_dest),
    .wb1_en      (wb1_en),
    .wb1_dest    (wb1_dest),
    .issue_en    (issue_en),
    .issue_dest  (issue_dest),
    .hazard      (hazard),
    .pending_cnt (pending_cnt)
  );

endmodule
